// File: rtl/vga_text_console.sv
// -----------------------------------------------------------------------------
// vga_text_console
//   Text-mode console for a 640x480 VGA path. Bytes arrive on a valid/ready
//   port and are written into a COLS x ROWS character buffer. The console keeps
//   a cursor and handles line wrap, backspace and newline. Scrolling moves a
//   circular row base instead of copying the buffer. A free-running pipeline
//   turns h_addr/v_addr into pixels through an external font ROM and overlays a
//   blinking underline cursor.
//
// Ports
//   clk        pixel clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   ch_valid   byte offered
//   ch_data    ASCII byte
//   ch_ready   console accepts a byte this cycle (only while idle)
//   h_addr     current pixel column from vga_ctrl
//   v_addr     current pixel row from vga_ctrl
//   font_addr  font ROM address = char*CHAR_H + scanline (registered)
//   font_data  font ROM row, one cycle after font_addr, bit0 = leftmost pixel
//   vga_data   pixel RGB, three cycles after h_addr/v_addr
//   cur_col    cursor column
//   cur_row    cursor logical row (0 = top of the screen)
// -----------------------------------------------------------------------------
module vga_text_console #(
    parameter int          COLS      = 70,
    parameter int          ROWS      = 30,
    parameter int          CHAR_W    = 9,
    parameter int          CHAR_H    = 16,
    parameter logic [23:0] FG        = 24'hFFFFFF,
    parameter logic [23:0] BG        = 24'h000000,
    parameter int          BLINK_DIV = 12500000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ch_valid,
    input  logic [7:0]                ch_data,
    output logic                      ch_ready,
    input  logic [9:0]                h_addr,
    input  logic [9:0]                v_addr,
    output logic [11:0]               font_addr,
    input  logic [CHAR_W-1:0]         font_data,
    output logic [23:0]               vga_data,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int RW1   = RW + 1;
    localparam int PXW   = $clog2(CHAR_W);
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        S_CLR_ALL = 2'd0,
        S_IDLE    = 2'd1,
        S_WRITE   = 2'd2,
        S_CLR_ROW = 2'd3
    } state_t;

    // Sum of two row indices (each < ROWS) reduced modulo ROWS.
    function automatic logic [RW-1:0] wrap_row(input logic [RW:0] sum);
        if (sum >= RW1'(ROWS)) begin
            return RW'(sum - RW1'(ROWS));
        end else begin
            return RW'(sum);
        end
    endfunction

    // Linear buffer address of a physical row / column pair.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                                input logic [CW-1:0] pcol);
        return AW'(prow) * AW'(COLS) + AW'(pcol);
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   base_q, base_d;
    logic [7:0]      byte_q, byte_d;
    logic            ready_q;
    logic            we_s;
    logic [AW-1:0]   waddr_s;
    logic [7:0]      wdata_s;
    logic            newline_s;
    logic [RW-1:0]   wr_row_s;
    logic [RW-1:0]   bot_row_s;
    logic [7:0]      mem [CELLS];

    logic [BW-1:0]   blink_cnt_q;
    logic            blink_q;

    logic [9:0]      txt_col_s, txt_row_s, sub_s;
    logic [PXW-1:0]  px_s;
    logic            inside_s, hit_s;
    logic [RW-1:0]   rd_row_s;
    logic [AW-1:0]   rd_addr_s;
    logic [7:0]      rd_ch_s;
    logic [PXW-1:0]  px1_q, px2_q;
    logic            in1_q, in2_q, hit1_q, hit2_q;
    logic [23:0]     vga_d;

    // Physical row of the cursor, and the physical row that is the new bottom line
    // right after a scroll (the row that just left the top of the screen).
    assign wr_row_s  = wrap_row(RW1'(base_q) + RW1'(row_q));
    assign bot_row_s = (base_q == '0) ? RW'(ROWS - 1) : base_q - RW'(1);

    // Console FSM: clearing, byte acceptance, byte decode and cursor movement.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        base_d    = base_q;
        byte_d    = byte_q;
        we_s      = 1'b0;
        waddr_s   = '0;
        wdata_s   = 8'h20;
        newline_s = 1'b0;
        case (state_q)
            S_CLR_ALL: begin
                we_s    = 1'b1;
                waddr_s = clr_cnt_q;
                if (clr_cnt_q == AW'(CELLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (ch_valid && ready_q) begin
                    byte_d  = ch_data;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    we_s    = 1'b1;
                    waddr_s = cell_addr(wr_row_s, col_q);
                    wdata_s = byte_q;
                    if (col_q == CW'(COLS - 1)) begin
                        newline_s = 1'b1;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else if (byte_q == 8'h0A || byte_q == 8'h0D) begin
                    newline_s = 1'b1;
                end else if (byte_q == 8'h08) begin
                    // Backspace never wraps back to the previous line.
                    if (col_q != '0) begin
                        col_d   = col_q - CW'(1);
                        we_s    = 1'b1;
                        waddr_s = cell_addr(wr_row_s, col_q - CW'(1));
                    end else begin
                        col_d = col_q;
                    end
                end else begin
                    newline_s = 1'b0;
                end
                if (newline_s) begin
                    col_d = '0;
                    if (row_q != RW'(ROWS - 1)) begin
                        row_d = row_q + RW'(1);
                    end else begin
                        // Scroll: advance the base; the old top row becomes the bottom.
                        base_d    = (base_q == RW'(ROWS - 1)) ? '0 : base_q + RW'(1);
                        clr_cnt_d = '0;
                        state_d   = S_CLR_ROW;
                    end
                end else begin
                    row_d = row_q;
                end
            end
            S_CLR_ROW: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(bot_row_s, CW'(clr_cnt_q));
                if (clr_cnt_q == AW'(COLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                clr_cnt_d = '0;
                state_d   = S_CLR_ALL;
            end
        endcase
    end

    // Console state registers; ready is registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CLR_ALL;
            clr_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            byte_q    <= 8'h00;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            base_q    <= base_d;
            byte_q    <= byte_d;
            ready_q   <= (state_d == S_IDLE);
        end
    end

    // Character buffer write port.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    // Cursor blink: toggle every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    // Render stage 0: split the pixel position into cell, scanline and pixel.
    assign txt_col_s = h_addr / 10'(CHAR_W);
    assign txt_row_s = v_addr / 10'(CHAR_H);
    assign sub_s     = v_addr % 10'(CHAR_H);
    assign px_s      = PXW'(h_addr % 10'(CHAR_W));
    assign inside_s  = (txt_col_s < 10'(COLS)) && (txt_row_s < 10'(ROWS));
    assign rd_row_s  = wrap_row(RW1'(base_q) + RW1'(txt_row_s[RW-1:0]));
    assign rd_addr_s = inside_s ? cell_addr(rd_row_s, txt_col_s[CW-1:0]) : '0;
    assign rd_ch_s   = mem[rd_addr_s];
    assign hit_s     = blink_q && inside_s &&
                       (txt_row_s == 10'(row_q)) && (txt_col_s == 10'(col_q)) &&
                       (sub_s >= 10'(CHAR_H - 2));

    // Final pixel colour from the delayed side-band and the font row.
    always_comb begin
        vga_d = BG;
        if (!in2_q) begin
            vga_d = BG;
        end else if (hit2_q) begin
            vga_d = FG;
        end else if (font_data[px2_q]) begin
            vga_d = FG;
        end else begin
            vga_d = BG;
        end
    end

    // Render stages 1..3: font address, side-band delay to meet font_data, pixel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            font_addr <= 12'd0;
            px1_q     <= '0;
            px2_q     <= '0;
            in1_q     <= 1'b0;
            in2_q     <= 1'b0;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            vga_data  <= 24'h000000;
        end else begin
            font_addr <= 12'(rd_ch_s) * 12'(CHAR_H) + 12'(sub_s);
            px1_q     <= px_s;
            in1_q     <= inside_s;
            hit1_q    <= hit_s;
            px2_q     <= px1_q;
            in2_q     <= in1_q;
            hit2_q    <= hit1_q;
            vga_data  <= vga_d;
        end
    end

    assign ch_ready = ready_q;
    assign cur_col  = col_q;
    assign cur_row  = row_q;

endmodule
